pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage RV64 pipeline. Detects load-use hazards against the ID_EX register, squashes wrong-path instructions on taken branches, and freezes the pipeline while the data memory is not ready. Drives write-enable and flush inputs of PC, IF_ID, ID_EX and EX_MEM. Keeps a stall-cycle performance counter and a sticky memory-timeout flag.

Parameters:
MEM_TIMEOUT, 64, MEM_WAIT cycles without dmem_ready before mem_timeout sets (>=2)
STALL_CNT_W, 32, width of saturating stall_count

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-low reset
id_rs1  in  5  rs1 of instruction in ID (IF_ID)
id_rs2  in  5  rs2 of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_memread  in  1  MemRead_out of ID_EX
ex_rd  in  5  rd_out of ID_EX
ex_branch_taken  in  1  branch/jump resolved taken in EX
mem_req  in  1  EX_MEM MemRead or MemWrite active
dmem_ready  in  1  data memory completes access this cycle
pc_write  out  1  PC update enable
if_id_write  out  1  IF_ID load enable
id_ex_write  out  1  ID_EX load enable
ex_mem_write  out  1  EX_MEM load enable
if_id_flush  out  1  zero IF_ID on next edge
id_ex_flush  out  1  load bubble (all controls 0) into ID_EX
mem_timeout  out  1  sticky MEM_WAIT timeout
stall_count  out  STALL_CNT_W  cycles with pc_write=0, saturating

Behaviour:
- States (shared enum): RUN, MEM_WAIT. Registers: state, wait_cnt, mem_timeout, stall_count.
- rst=0 (async): state=RUN, wait_cnt=0, mem_timeout=0, stall_count=0. While rst=0 all *_write=0, both flushes=0.
- Control outputs are combinational from inputs + state, zero latency (affect the next clock edge).
- mem_stall = mem_req & ~dmem_ready. lu_hazard = ex_memread & ex_rd!=0 & ((id_uses_rs1 & ex_rd==id_rs1) | (id_uses_rs2 & ex_rd==id_rs2)).
- Priority, highest first:
  1. mem_stall (RUN or MEM_WAIT): all four *_write=0, flushes=0. Branch and load-use are held, not acted on.
  2. ex_branch_taken: all *_write=1, if_id_flush=1, id_ex_flush=1. Load-use is ignored because the ID instruction is squashed.
  3. lu_hazard: pc_write=0, if_id_write=0, id_ex_write=1, id_ex_flush=1, ex_mem_write=1. The one bubble clears ex_memread, so the stall lasts exactly one cycle.
  4. Otherwise: all *_write=1, flushes=0.
- Transitions:
  - RUN -> MEM_WAIT when mem_stall, with wait_cnt<=1.
  - MEM_WAIT -> RUN on the cycle dmem_ready=1. Outputs in that cycle follow priorities 2-4, so there is no dead cycle.
  - In MEM_WAIT, wait_cnt increments and saturates at MEM_TIMEOUT. When wait_cnt==MEM_TIMEOUT-1 and mem_stall, mem_timeout<=1. The pipeline remains frozen.
  - mem_timeout clears only on reset.
- stall_count increments on every edge where pc_write=0 and rst=1. It holds at all-ones.
- ex_rd==0 never causes a hazard.
- Reset asserted mid-MEM_WAIT aborts immediately to RUN.

Decomposition:
- pipe_ctrl_pkg: ctrl_state_e {RUN, MEM_WAIT}, REG_ADDR_W=5, REG_ZERO=5'd0.
- One combinational sub-module, load_use_detect (id_rs1/2, id_uses_rs1/2, ex_memread, ex_rd -> lu_hazard), reused by formal checks.

Test Plan:
- Reset release, all inputs 0 -> all *_write=1, flushes=0, stall_count=0, mem_timeout=0.
- ex_memread=1, ex_rd=5, id_rs2=5, id_uses_rs2=1, one cycle -> pc_write=0, if_id_write=0, id_ex_flush=1 for exactly 1 cycle; stall_count=1. Repeat with ex_rd=0 -> no stall.
- lu_hazard and ex_branch_taken in the same cycle -> if_id_flush=1, id_ex_flush=1, pc_write=1; stall_count unchanged.
- mem_req=1, dmem_ready=0 for 3 cycles, then 1 -> all writes 0 for 3 cycles, all 1 on the 4th; state returns to RUN; stall_count=3.
- MEM_TIMEOUT=4, mem_req=1, dmem_ready=0 for 6 cycles -> mem_timeout=1 after the 4th stalled edge. It stays 1 after dmem_ready=1 and clears only on rst=0.
- rst=0 asserted mid-MEM_WAIT (no clock edge) -> outputs drop to 0 immediately. After release: state=RUN, stall_count=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
//   ctrl_state_e : controller state (RUN, MEM_WAIT)
//   REG_ADDR_W   : register-file address width
//   REG_ZERO     : address of the hard-wired zero register
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } ctrl_state_e;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector.
// Inputs : id_rs1/id_rs2 and their use flags (instruction in ID),
//          ex_memread/ex_rd (load sitting in ID_EX).
// Output : lu_hazard, high when the ID instruction reads the register the
//          EX-stage load is about to write. x0 never creates a hazard.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  lu_hazard
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = id_uses_rs1 && (ex_rd == id_rs1);
  assign rs2_match = id_uses_rs2 && (ex_rd == id_rs2);
  assign lu_hazard = ex_memread && (ex_rd != REG_ZERO) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Inputs : ID source registers and use flags, ID_EX load info, EX branch
//          resolution, EX_MEM memory request and data-memory ready.
// Outputs: load enables for PC, IF_ID, ID_EX, EX_MEM; flushes for IF_ID and
//          ID_EX; sticky mem_timeout; saturating stall_count (cycles with
//          pc_write low).
// Control outputs are combinational so they act on the very next edge.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_ADDR_W-1:0]  id_rs1,
  input  logic [REG_ADDR_W-1:0]  id_rs2,
  input  logic                   id_uses_rs1,
  input  logic                   id_uses_rs2,
  input  logic                   ex_memread,
  input  logic [REG_ADDR_W-1:0]  ex_rd,
  input  logic                   ex_branch_taken,
  input  logic                   mem_req,
  input  logic                   dmem_ready,
  output logic                   pc_write,
  output logic                   if_id_write,
  output logic                   id_ex_write,
  output logic                   ex_mem_write,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output logic                   mem_timeout,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  ctrl_state_e       state_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic              lu_hazard;
  logic              mem_stall;

  assign mem_stall = mem_req && !dmem_ready;

  load_use_detect u_load_use_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_memread  (ex_memread),
    .ex_rd       (ex_rd),
    .lu_hazard   (lu_hazard)
  );

  // A memory stall freezes everything and holds pending branch/load-use
  // events; a taken branch squashes the ID instruction so load-use is moot.
  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    id_ex_write  = 1'b0;
    ex_mem_write = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    if (rst && !mem_stall) begin
      id_ex_write  = 1'b1;
      ex_mem_write = 1'b1;
      if (ex_branch_taken) begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (lu_hazard) begin
        // One bubble into ID_EX clears ex_memread, ending the stall.
        id_ex_flush = 1'b1;
      end else begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= RUN;
      wait_cnt_reg <= '0;
      mem_timeout  <= 1'b0;
      stall_count  <= '0;
    end else begin
      if (!pc_write && (stall_count != '1)) begin
        stall_count <= stall_count + STALL_CNT_W'(1);
      end
      case (state_reg)
        RUN: begin
          if (mem_stall) begin
            state_reg    <= MEM_WAIT;
            wait_cnt_reg <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (!mem_stall) begin
            state_reg    <= RUN;
            wait_cnt_reg <= '0;
          end else begin
            if (wait_cnt_reg == WAIT_LAST) begin
              mem_timeout <= 1'b1;
            end
            if (wait_cnt_reg != WAIT_MAX) begin
              wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
            end
          end
        end
        default: begin
          state_reg    <= RUN;
          wait_cnt_reg <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int MT  = 4;
  localparam int SCW = 4;
  localparam int SAT = (1 << SCW) - 1;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [4:0]     id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic           id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, ex_memread = 1'b0;
  logic           ex_branch_taken = 1'b0, mem_req = 1'b0, dmem_ready = 1'b0;
  logic           pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic           if_id_flush, id_ex_flush, mem_timeout;
  logic [SCW-1:0] stall_count;
  logic [5:0]     ctrl;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_cnt = 0;
  int m_run = 0;
  bit m_to  = 1'b0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MT), .STALL_CNT_W(SCW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_memread(ex_memread), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write),
    .id_ex_write(id_ex_write), .ex_mem_write(ex_mem_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_timeout(mem_timeout), .stall_count(stall_count)
  );

  // {pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_flush}
  assign ctrl = {pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_flush};

  localparam logic [5:0] C_ZERO   = 6'b000000;
  localparam logic [5:0] C_NORMAL = 6'b111100;
  localparam logic [5:0] C_BRANCH = 6'b111111;
  localparam logic [5:0] C_LU     = 6'b001101;

  // Priority rules applied directly to the current inputs.
  function automatic logic [5:0] model_ctrl();
    bit stall, hz;
    stall = mem_req && !dmem_ready;
    hz = ex_memread && (ex_rd != 0) &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    if (!rst)                 return C_ZERO;
    else if (stall)           return C_ZERO;
    else if (ex_branch_taken) return C_BRANCH;
    else if (hz)              return C_LU;
    else                      return C_NORMAL;
  endfunction

  // Model bookkeeping for one clock edge: counts stalled PC cycles and
  // the length of the current unbroken memory-stall run.
  task automatic model_edge();
    logic [5:0] e;
    e = model_ctrl();
    if (!e[5] && m_cnt < SAT) m_cnt++;
    if (mem_req && !dmem_ready) m_run++;
    else m_run = 0;
    if (m_run >= MT) m_to = 1'b1;
  endtask

  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ex_memread = 0;
    ex_branch_taken = 0; mem_req = 0; dmem_ready = 0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_cnt = 0; m_run = 0; m_to = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    #2;
    checks++;
    if (ctrl !== C_ZERO) begin
      errors++; $display("FAIL reset_ctrl: got %b want %b", ctrl, C_ZERO);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ctrl !== C_NORMAL) begin
      errors++; $display("FAIL reset_release_ctrl: got %b want %b", ctrl, C_NORMAL);
    end
    checks++;
    if (stall_count !== 0 || mem_timeout !== 1'b0) begin
      errors++; $display("FAIL reset_regs: got cnt=%0d to=%b want 0/0", stall_count, mem_timeout);
    end
    @(posedge clk); #1;
    $display("test_reset done");
  endtask

  task automatic test_load_use();
    apply_reset();
    ex_memread = 1; ex_rd = 5; id_rs2 = 5; id_uses_rs2 = 1;
    @(negedge clk);
    checks++;
    if (ctrl !== C_LU) begin
      errors++; $display("FAIL lu_stall: got %b want %b", ctrl, C_LU);
    end
    @(posedge clk); #1;
    ex_memread = 0;  // bubble now in ID_EX
    @(negedge clk);
    checks++;
    if (ctrl !== C_NORMAL || stall_count !== 1) begin
      errors++; $display("FAIL lu_after: got %b cnt=%0d want %b cnt=1", ctrl, stall_count, C_NORMAL);
    end
    @(posedge clk); #1;
    ex_memread = 1; ex_rd = 0; id_rs2 = 0; id_rs1 = 0; id_uses_rs1 = 1;
    @(negedge clk);
    checks++;
    if (ctrl !== C_NORMAL) begin
      errors++; $display("FAIL lu_x0: got %b want %b", ctrl, C_NORMAL);
    end
    @(posedge clk); #1;
    checks++;
    if (stall_count !== 1) begin
      errors++; $display("FAIL lu_x0_cnt: got %0d want 1", stall_count);
    end
    $display("test_load_use done");
  endtask

  task automatic test_branch_over_lu();
    apply_reset();
    ex_memread = 1; ex_rd = 7; id_rs1 = 7; id_uses_rs1 = 1; ex_branch_taken = 1;
    @(negedge clk);
    checks++;
    if (ctrl !== C_BRANCH) begin
      errors++; $display("FAIL branch_lu: got %b want %b", ctrl, C_BRANCH);
    end
    @(posedge clk); #1;
    checks++;
    if (stall_count !== 0) begin
      errors++; $display("FAIL branch_lu_cnt: got %0d want 0", stall_count);
    end
    $display("test_branch_over_lu done");
  endtask

  task automatic test_mem_stall();
    apply_reset();
    mem_req = 1; dmem_ready = 0; ex_branch_taken = 1;  // branch is held
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ctrl !== C_ZERO) begin
        errors++; $display("FAIL mem_stall_%0d: got %b want %b", i, ctrl, C_ZERO);
      end
      @(posedge clk); #1;
    end
    ex_branch_taken = 0; dmem_ready = 1;
    @(negedge clk);
    checks++;
    if (ctrl !== C_NORMAL || stall_count !== 3) begin
      errors++; $display("FAIL mem_release: got %b cnt=%0d want %b cnt=3", ctrl, stall_count, C_NORMAL);
    end
    @(posedge clk); #1;
    mem_req = 0; dmem_ready = 0;
    @(negedge clk);
    checks++;
    if (ctrl !== C_NORMAL || stall_count !== 3) begin
      errors++; $display("FAIL mem_run: got %b cnt=%0d want %b cnt=3", ctrl, stall_count, C_NORMAL);
    end
    @(posedge clk); #1;
    $display("test_mem_stall done");
  endtask

  task automatic test_timeout();
    apply_reset();
    mem_req = 1; dmem_ready = 0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      checks++;
      if (mem_timeout !== (i >= MT)) begin
        errors++; $display("FAIL timeout_edge%0d: got %b want %b", i, mem_timeout, (i >= MT));
      end
    end
    dmem_ready = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (mem_timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_sticky: got %b want 1", mem_timeout);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (mem_timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_clear: got %b want 0", mem_timeout);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    $display("test_timeout done");
  endtask

  task automatic test_reset_mid_wait();
    apply_reset();
    mem_req = 1; dmem_ready = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    dmem_ready = 1;  // would unfreeze, but reset overrides
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (ctrl !== C_ZERO || stall_count !== 0) begin
      errors++; $display("FAIL mid_reset: got %b cnt=%0d want %b cnt=0", ctrl, stall_count, C_ZERO);
    end
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (ctrl !== C_NORMAL || stall_count !== 0) begin
      errors++; $display("FAIL mid_reset_release: got %b cnt=%0d want %b cnt=0", ctrl, stall_count, C_NORMAL);
    end
    @(posedge clk); #1;
    checks++;
    if (stall_count !== 0) begin
      errors++; $display("FAIL mid_reset_run: got cnt=%0d want 0", stall_count);
    end
    $display("test_reset_mid_wait done");
  endtask

  task automatic test_random();
    logic [5:0] e;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      id_rs1 = 5'($urandom_range(0, 3));
      id_rs2 = 5'($urandom_range(0, 3));
      ex_rd  = 5'($urandom_range(0, 3));
      id_uses_rs1 = 1'($urandom_range(0, 1));
      id_uses_rs2 = 1'($urandom_range(0, 1));
      ex_memread  = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      mem_req    = ($urandom_range(0, 2) == 0);
      dmem_ready = ($urandom_range(0, 4) == 0);
      @(negedge clk);
      e = model_ctrl();
      checks++;
      if (ctrl !== e) begin
        errors++; $display("FAIL rand_ctrl[%0d]: got %b want %b", n, ctrl, e);
      end
      checks++;
      if (stall_count !== SCW'(m_cnt) || mem_timeout !== m_to) begin
        errors++; $display("FAIL rand_regs[%0d]: got cnt=%0d to=%b want cnt=%0d to=%b",
                           n, stall_count, mem_timeout, m_cnt, m_to);
      end
      @(posedge clk);
      model_edge();
      #1;
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_over_lu();
    test_mem_stall();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
